// File: rtl/ternary_pkg.sv
// rtl/ternary_pkg.sv - balanced-ternary trit encoding shared by BTISA blocks
package ternary_pkg;

    typedef enum logic [1:0] {
        T_ZERO = 2'b00,
        T_POS  = 2'b01,
        T_NEG  = 2'b11
    } trit_t;

    typedef trit_t [8:0] instr_t;

endpackage

// File: rtl/btisa_encoder_if.sv
// rtl/btisa_encoder_if.sv - field-set input and packed-word output handshakes of btisa_encoder
interface btisa_encoder_if #(
    parameter int ADDR_W = 8
);

    logic                      in_valid;
    logic                      in_ready;
    logic signed [4:0]         in_op;
    logic signed [3:0]         in_rd;
    logic signed [3:0]         in_rs1;
    logic signed [3:0]         in_imm;
    logic                      out_valid;
    logic                      out_ready;
    ternary_pkg::trit_t [8:0]  out_instr;
    logic [ADDR_W-1:0]         out_addr;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

endinterface

// File: rtl/btisa_encoder.sv
// rtl/btisa_encoder.sv - BTISA field-to-trit encoder with 2-entry tagged output FIFO
// Optional feature: BTISA_ENC_RANGE_CHECK_EN rejects out-of-range fields instead of wrapping them.
module btisa_encoder
    import ternary_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    btisa_encoder_if.slave     bus,
    input  logic               restart,
    output logic               done,
    output logic               err,
    output logic [7:0]         err_count
);

    typedef enum logic {RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         count;
    instr_t             e0_instr, e1_instr, new_instr;
    logic [ADDR_W-1:0]  e0_addr, e1_addr, addr_cnt;
    logic               accept, legal, push, pop, is_halt;
    trit_t [2:0]        op_t, rd_t, rs1_t, imm_t;

    // Fold a value into its balanced range; one step covers every representable input.
    function automatic logic signed [6:0] wrap27(input logic signed [4:0] v);
        logic signed [6:0] x;
        x = {{2{v[4]}}, v};
        if (x > 7'sd13)       x = x - 7'sd27;
        else if (x < -7'sd13) x = x + 7'sd27;
        return x;
    endfunction

    function automatic logic signed [6:0] wrap9(input logic signed [3:0] v);
        logic signed [6:0] x;
        x = {{3{v[3]}}, v};
        if (x > 7'sd4)       x = x - 7'sd9;
        else if (x < -7'sd4) x = x + 7'sd9;
        return x;
    endfunction

    // Balanced digit extraction: remainder of +-2 becomes -+1 with a carry into the next trit.
    function automatic trit_t [2:0] enc3(input logic signed [6:0] v);
        logic signed [6:0] x, m, r;
        trit_t [2:0]       t;
        x = v;
        t = {T_ZERO, T_ZERO, T_ZERO};
        for (int i = 0; i < 3; i++) begin
            m = x % 7'sd3;
            r = (m == 7'sd2) ? -7'sd1 : ((m == -7'sd2) ? 7'sd1 : m);
            t[i] = (r == 7'sd1) ? T_POS : ((r == -7'sd1) ? T_NEG : T_ZERO);
            x = (x - r) / 7'sd3;
        end
        return t;
    endfunction

    always_comb begin
        op_t  = enc3(wrap27(bus.in_op));
        rd_t  = enc3(wrap9(bus.in_rd));
        rs1_t = enc3(wrap9(bus.in_rs1));
        imm_t = enc3(wrap9(bus.in_imm));
        new_instr[8:6] = op_t;
        new_instr[5:4] = rd_t[1:0];
        new_instr[3:2] = rs1_t[1:0];
        new_instr[1:0] = imm_t[1:0];
    end

`ifdef BTISA_ENC_RANGE_CHECK_EN
    assign legal = (bus.in_op  >= -5'sd13) && (bus.in_op  <= 5'sd13) &&
                   (bus.in_rd  >= -4'sd4)  && (bus.in_rd  <= 4'sd4)  &&
                   (bus.in_rs1 >= -4'sd4)  && (bus.in_rs1 <= 4'sd4)  &&
                   (bus.in_imm >= -4'sd4)  && (bus.in_imm <= 4'sd4);
`else
    assign legal = 1'b1;
`endif

    assign bus.in_ready  = (state == RUN) && (count != 2'd2);
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && legal;
    assign pop           = bus.out_valid && bus.out_ready;
    assign is_halt       = (bus.in_op == -5'sd11);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = e0_instr;
    assign bus.out_addr  = e0_addr;
    assign done          = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // restart beats a simultaneous HALT accept, so the program stays open.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (!restart && push && is_halt) state_nxt = DONE;
            DONE:    if (restart) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= '0;
        end else if (restart) begin
            addr_cnt <= '0;
        end else if (push) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 2'd0;
            e0_instr <= instr_t'(18'd0);
            e1_instr <= instr_t'(18'd0);
            e0_addr  <= '0;
            e1_addr  <= '0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    e0_instr <= e1_instr;
                    e0_addr  <= e1_addr;
                    count    <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        e0_instr <= new_instr;
                        e0_addr  <= addr_cnt;
                    end else begin
                        e1_instr <= new_instr;
                        e1_addr  <= addr_cnt;
                    end
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        e0_instr <= new_instr;
                        e0_addr  <= addr_cnt;
                    end else begin
                        e0_instr <= e1_instr;
                        e0_addr  <= e1_addr;
                        e1_instr <= new_instr;
                        e1_addr  <= addr_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BTISA_ENC_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (accept && !legal) begin
            err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`else
    assign err       = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_btisa_encoder.sv
// tb/tb_btisa_encoder.sv - self-checking bench for btisa_encoder (table vectors + scoreboard)
module tb_btisa_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic       restart2 = 1'b0;
    logic       done, err, done2, err2;
    logic [7:0] err_count, err_count2;

    always #5 clk = ~clk;

    btisa_encoder_if #(.ADDR_W(8)) bus ();
    btisa_encoder_if #(.ADDR_W(2)) bus2 ();

    btisa_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .restart(restart),
        .done(done), .err(err), .err_count(err_count)
    );

    btisa_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .restart(restart2),
        .done(done2), .err(err2), .err_count(err_count2)
    );

    typedef struct { logic [17:0] w; int addr; } exp_t;
    typedef struct { int op; int rd; int rs1; int imm; string exp_s; } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;
    int   exp_addr = 0;
    int   exp_errs = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] str2w(input string s);
        logic [17:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) begin
            byte c;
            c = s[i];
            w[17-2*i -: 2] = (c == "+") ? 2'b01 : ((c == "-") ? 2'b11 : 2'b00);
        end
        return w;
    endfunction

    function automatic int red(input int v, input int h, input int m);
        return (((v + h) % m) + m) % m - h;
    endfunction

    // Brute-force search over all trit triples; independent of the RTL digit recurrence.
    function automatic logic [5:0] trits(input int v);
        logic [5:0] b;
        b = '0;
        for (int a = -1; a <= 1; a++)
            for (int bb = -1; bb <= 1; bb++)
                for (int c = -1; c <= 1; c++)
                    if (9*a + 3*bb + c == v) begin
                        b[5:4] = (a  == 1) ? 2'b01 : ((a  == -1) ? 2'b11 : 2'b00);
                        b[3:2] = (bb == 1) ? 2'b01 : ((bb == -1) ? 2'b11 : 2'b00);
                        b[1:0] = (c  == 1) ? 2'b01 : ((c  == -1) ? 2'b11 : 2'b00);
                    end
        return b;
    endfunction

    function automatic logic [17:0] model_enc(input int op, input int rd, input int rs1, input int imm);
        logic [5:0] o, d, s1, im;
        o  = trits(red(op, 13, 27));
        d  = trits(red(rd, 4, 9));
        s1 = trits(red(rs1, 4, 9));
        im = trits(red(imm, 4, 9));
        return {o, d[3:0], s1[3:0], im[3:0]};
    endfunction

    function automatic bit tb_legal(input int op, input int rd, input int rs1, input int imm);
`ifdef BTISA_ENC_RANGE_CHECK_EN
        return (op >= -13 && op <= 13 && rd >= -4 && rd <= 4 &&
                rs1 >= -4 && rs1 <= 4 && imm >= -4 && imm <= 4);
`else
        return 1'b1;
`endif
    endfunction

    task automatic send(input int op, input int rd, input int rs1, input int imm,
                        input logic [17:0] w, input bit with_restart);
        int n;
        bit lg;
        lg = tb_legal(op, rd, rs1, imm);
        bus.in_valid = 1'b1;
        bus.in_op    = 5'(op);
        bus.in_rd    = 4'(rd);
        bus.in_rs1   = 4'(rs1);
        bus.in_imm   = 4'(imm);
        if (with_restart) restart = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=0 required=1");
            bus.in_valid = 1'b0;
            restart = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        restart = 1'b0;
        if (lg) begin
            sbq.push_back('{w, exp_addr});
            exp_addr = (exp_addr + 1) % 256;
        end else if (exp_errs < 255) begin
            exp_errs++;
        end
        if (with_restart) exp_addr = 0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((sbq.size() != 0 || bus.out_valid) && n < 40) begin
            tick();
            n++;
        end
        if (sbq.size() != 0 || bus.out_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop addr=%0d required=none", bus.out_addr);
            end else begin
                exp_t e;
                logic [17:0] g;
                e = sbq.pop_front();
                g = bus.out_instr;
                chk("sb_instr", 32'(g), 32'(e.w));
                chk("sb_addr", 32'(bus.out_addr), 32'(e.addr));
            end
        end
    end

    initial begin
        vecs[0] = '{0, 1, 2, -1, "0000++-0-"};
        vecs[1] = '{13, 4, -4, 0, "+++++--00"};
        vecs[2] = '{-13, -4, 4, -3, "-----++-0"};
        vecs[3] = '{5, 3, -2, 2, "+--+0-++-"};
        vecs[4] = '{-7, 0, 1, -1, "-+-000+0-"};
        vecs[5] = '{7, -1, 0, 3, "+-+0-00+0"};
        vecs[6] = '{14, 5, -8, 7, "-----0+-+"};
        vecs[7] = '{-14, -5, 4, -4, "+++++++--"};

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_imm = '0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_op = '0; bus2.in_rd = '0; bus2.in_rs1 = '0; bus2.in_imm = '0;
        bus2.out_ready = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", 32'(18'(bus.out_instr)), 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        // first word appears the cycle after accept
        send(vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].imm, str2w(vecs[0].exp_s), 1'b0);
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_out_instr", 32'(18'(bus.out_instr)), 32'(str2w("0000++-0-")));
        chk("lat_out_addr", 32'(bus.out_addr), 32'd0);
        bus.out_ready = 1'b1;

        for (int i = 0; i < 8; i++)
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].imm, str2w(vecs[i].exp_s), 1'b0);
        wait_empty();
        chk("tbl_err", 32'(err), 32'(exp_errs != 0));
        chk("tbl_err_count", 32'(err_count), 32'(exp_errs));

`ifdef BTISA_ENC_RANGE_CHECK_EN
        send(0, 5, 0, 0, model_enc(0, 5, 0, 0), 1'b0);
        chk("rng_err", 32'(err), 32'd1);
        chk("rng_err_count", 32'(err_count), 32'(exp_errs));
        send(1, 1, 1, 1, model_enc(1, 1, 1, 1), 1'b0);
`else
        send(0, 5, 0, 0, str2w("000--0000"), 1'b0);
        chk("wrap_err", 32'(err), 32'd0);
`endif
        wait_empty();

        // backpressure: two fill the FIFO, third waits for the first pop
        bus.out_ready = 1'b0;
        send(2, 1, 0, 0, model_enc(2, 1, 0, 0), 1'b0);
        send(3, 0, 1, 0, model_enc(3, 0, 1, 0), 1'b0);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        fork
            send(4, 0, 0, 1, model_enc(4, 0, 0, 1), 1'b0);
            begin
                tick();
                tick();
                chk("held_in_ready", 32'(bus.in_ready), 32'd0);
                bus.out_ready = 1'b1;
                chk("pop_cycle_in_ready", 32'(bus.in_ready), 32'd0);
                tick();
                chk("reassert_in_ready", 32'(bus.in_ready), 32'd1);
            end
        join
        wait_empty();

        // HALT closes the program until restart
        send(-11, 0, 0, 0, str2w("--+000000"), 1'b0);
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) tick();
        chk("halt_hold_in_ready", 32'(bus.in_ready), 32'd0);
        restart = 1'b1;
        exp_addr = 0;
        tick();
        restart = 1'b0;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
        send(1, 2, 3, 4, model_enc(1, 2, 3, 4), 1'b0);
        send(-1, -2, -3, -4, model_enc(-1, -2, -3, -4), 1'b0);

        // restart in RUN only clears the address counter
        restart = 1'b1;
        exp_addr = 0;
        tick();
        restart = 1'b0;
        send(6, 0, 0, 0, model_enc(6, 0, 0, 0), 1'b0);

        // restart together with HALT: restart wins
        send(-11, 1, 1, 1, model_enc(-11, 1, 1, 1), 1'b1);
        chk("halt_restart_done", 32'(done), 32'd0);
        chk("halt_restart_in_ready", 32'(bus.in_ready), 32'd1);
        send(9, -1, -1, -1, model_enc(9, -1, -1, -1), 1'b0);
        wait_empty();

        // reset with two entries pending
        bus.out_ready = 1'b0;
        send(2, 2, 2, 2, model_enc(2, 2, 2, 2), 1'b0);
        send(-11, 0, 0, 0, model_enc(-11, 0, 0, 0), 1'b0);
        chk("pre_rst_done", 32'(done), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        sbq.delete();
        exp_addr = 0;
        exp_errs = 0;
        bus.out_ready = 1'b1;
        send(3, 3, 3, 3, model_enc(3, 3, 3, 3), 1'b0);
        wait_empty();

        // narrow address tag wraps at 4, one word per cycle
        bus2.out_ready = 1'b1;
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.in_op = 5'(i);
            tick();
            chk("w2_out_valid", 32'(bus2.out_valid), 32'd1);
            chk("w2_out_addr", 32'(bus2.out_addr), 32'(i % 4));
            chk("w2_out_instr", 32'(18'(bus2.out_instr)), 32'(model_enc(i, 0, 0, 0)));
            chk("w2_in_ready", 32'(bus2.in_ready), 32'd1);
        end
        bus2.in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
